// File: rtl/mcdt_pkg.sv
// Constants and types shared between the mcdt arbiter and its receive-side demux.
package mcdt_pkg;

  localparam int NUM_CHNL      = 3;
  localparam int DEFAULT_DW    = 32;
  localparam int DEFAULT_DEPTH = 32;

  typedef logic [1:0] chnl_id_t;

  localparam chnl_id_t ID_ILLEGAL = 2'd3;

endpackage

// File: rtl/rx_chnl_fifo.sv
// Single-clock per-channel FIFO: first-word-fall-through head register,
// valid/ready pop, free-slot margin and a one-cycle overflow pulse.
module rx_chnl_fifo
  import mcdt_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [$clog2(DEPTH):0]   margin_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [MW-1:0] count_q, count_d, margin_q, margin_d;
  logic [DW-1:0] data_q, data_d;
  logic          pop, full, wr;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pop      = (count_q != '0) && rd_ready_i;
    full     = (count_q == MW'(DEPTH));
    wr       = wr_en_i && (!full || pop);
    ovf_o    = wr_en_i && full && !pop;
    rd_next  = rd_ptr_q + 1'b1;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (wr && !pop) count_d = count_q + 1'b1;
    if (pop && !wr) count_d = count_q - 1'b1;
    // The head register must already hold the next word after the edge; a word
    // written this cycle bypasses storage when it becomes the new head.
    if (pop) begin
      if (count_q > MW'(1)) data_d = mem[rd_next];
      else if (wr)          data_d = wr_data_i;
    end else if (count_q == '0 && wr) begin
      data_d = wr_data_i;
    end
    margin_d = MW'(DEPTH) - count_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      margin_q <= MW'(DEPTH);
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      margin_q <= margin_d;
      data_q   <= data_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which words are live.
  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = (count_q != '0);
  assign margin_o   = margin_q;

endmodule

// File: rtl/mcdt_rx_demux.sv
// Splits the merged mcdt stream back into three buffered per-channel streams
// and keeps sticky overflow and illegal-id flags.
module mcdt_rx_demux
  import mcdt_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DW-1:0]          mcdt_data_i,
  input  logic                   mcdt_val_i,
  input  chnl_id_t               mcdt_id_i,
  output logic [DW-1:0]          ch0_data_o,
  output logic [DW-1:0]          ch1_data_o,
  output logic [DW-1:0]          ch2_data_o,
  output logic                   ch0_valid_o,
  output logic                   ch1_valid_o,
  output logic                   ch2_valid_o,
  input  logic                   ch0_ready_i,
  input  logic                   ch1_ready_i,
  input  logic                   ch2_ready_i,
  output logic [$clog2(DEPTH):0] ch0_margin_o,
  output logic [$clog2(DEPTH):0] ch1_margin_o,
  output logic [$clog2(DEPTH):0] ch2_margin_o,
  output logic [NUM_CHNL-1:0]    ovf_o,
  output logic                   id_err_o
);

  localparam int MW = $clog2(DEPTH) + 1;

  logic [NUM_CHNL-1:0] wr_en, ready, valid, ovf_pulse;
  logic [DW-1:0]       data   [NUM_CHNL];
  logic [MW-1:0]       margin [NUM_CHNL];
  logic [NUM_CHNL-1:0] ovf_q, ovf_d;
  logic                id_err_q, id_err_d;

  assign ready = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

  always_comb begin
    for (int n = 0; n < NUM_CHNL; n++) begin
      wr_en[n] = mcdt_val_i && (mcdt_id_i == chnl_id_t'(n));
    end
    ovf_d    = ovf_q | ovf_pulse;
    id_err_d = id_err_q || (mcdt_val_i && mcdt_id_i == ID_ILLEGAL);
  end

  for (genvar g = 0; g < NUM_CHNL; g++) begin : g_chnl
    rx_chnl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en[g]),
      .wr_data_i  (mcdt_data_i),
      .rd_data_o  (data[g]),
      .rd_valid_o (valid[g]),
      .rd_ready_i (ready[g]),
      .margin_o   (margin[g]),
      .ovf_o      (ovf_pulse[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q    <= '0;
      id_err_q <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      id_err_q <= id_err_d;
    end
  end

  assign ch0_data_o   = data[0];
  assign ch1_data_o   = data[1];
  assign ch2_data_o   = data[2];
  assign ch0_valid_o  = valid[0];
  assign ch1_valid_o  = valid[1];
  assign ch2_valid_o  = valid[2];
  assign ch0_margin_o = margin[0];
  assign ch1_margin_o = margin[1];
  assign ch2_margin_o = margin[2];
  assign ovf_o        = ovf_q;
  assign id_err_o     = id_err_q;

endmodule
